// File: rtl/axil_accel_pkg.sv
// Register map, bit positions and response codes shared by the accelerator
// control/status register file.
package axil_accel_pkg;

   localparam logic [31:0] REG_CTRL    = 32'h00;
   localparam logic [31:0] REG_STATUS  = 32'h04;
   localparam logic [31:0] REG_SRC     = 32'h08;
   localparam logic [31:0] REG_DST     = 32'h0C;
   localparam logic [31:0] REG_LEN     = 32'h10;
   localparam logic [31:0] REG_SCRATCH = 32'h14;
   localparam logic [31:0] REG_VERSION = 32'h18;

   localparam int CTRL_START    = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_SOFT_RST = 2;

   localparam int ST_BUSY      = 0;
   localparam int ST_DONE      = 1;
   localparam int ST_ERR       = 2;
   localparam int ST_START_OVR = 3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      SEL_CTRL, SEL_STATUS, SEL_SRC, SEL_DST, SEL_LEN, SEL_SCRATCH, SEL_VERSION, SEL_NONE
   } reg_sel_e;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++)
         if (strb[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
      return r;
   endfunction

   // Byte-lane bits of the address are ignored; only the word offset selects.
   function automatic reg_sel_e decode(input logic [31:0] byte_addr);
      reg_sel_e s;
      case ({byte_addr[31:2], 2'b00})
         REG_CTRL:    s = SEL_CTRL;
         REG_STATUS:  s = SEL_STATUS;
         REG_SRC:     s = SEL_SRC;
         REG_DST:     s = SEL_DST;
         REG_LEN:     s = SEL_LEN;
         REG_SCRATCH: s = SEL_SCRATCH;
         REG_VERSION: s = SEL_VERSION;
         default:     s = SEL_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/axil_accel_regs.sv
// AXI4-Lite control/status register file for the PL accelerator: start and
// soft-reset pulses, address/length config, sticky status and interrupt.
module axil_accel_regs
   import axil_accel_pkg::*;
#(
   parameter int          ADDR_WIDTH = 6,
   parameter logic [31:0] VERSION    = 32'h0001_0000
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [31:0]           s_axil_wdata,
   input  logic [3:0]            s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [31:0]           s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic                  acc_start,
   output logic                  acc_soft_rst,
   output logic [31:0]           acc_src_addr,
   output logic [31:0]           acc_dst_addr,
   output logic [23:0]           acc_len,
   input  logic                  acc_busy,
   input  logic                  acc_done,
   input  logic                  acc_err,
   output logic                  irq
);

   logic                  rdy_en_q, rdy_en_d;
   logic                  aw_held_q, aw_held_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic                  w_held_q, w_held_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  irq_en_q, irq_en_d;
   logic [31:0]           src_q, src_d;
   logic [31:0]           dst_q, dst_d;
   logic [23:0]           len_q, len_d;
   logic [31:0]           scratch_q, scratch_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  ovr_q, ovr_d;
   logic                  start_q, start_d;
   logic                  soft_rst_q, soft_rst_d;
   logic                  irq_q, irq_d;

   logic     aw_hs, w_hs, ar_hs, wr_commit, ctrl_b0;
   reg_sel_e wsel, rsel;

   assign s_axil_awready = rdy_en_q & ~aw_held_q & ~bvalid_q;
   assign s_axil_wready  = rdy_en_q & ~w_held_q & ~bvalid_q;
   assign s_axil_arready = rdy_en_q & ~rvalid_q;

   assign aw_hs     = s_axil_awvalid & s_axil_awready;
   assign w_hs      = s_axil_wvalid & s_axil_wready;
   assign ar_hs     = s_axil_arvalid & s_axil_arready;
   assign wr_commit = aw_held_q & w_held_q;
   assign wsel      = decode(32'(awaddr_q));
   assign rsel      = decode(32'(s_axil_araddr));
   assign ctrl_b0   = wr_commit & wstrb_q[0];

   always_comb begin
      rdy_en_d   = 1'b1;
      aw_held_d  = aw_held_q;
      awaddr_d   = awaddr_q;
      w_held_d   = w_held_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      irq_en_d   = irq_en_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      scratch_d  = scratch_q;
      done_d     = done_q;
      err_d      = err_q;
      ovr_d      = ovr_q;
      start_d    = 1'b0;
      soft_rst_d = 1'b0;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         awaddr_d  = s_axil_awaddr;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_axil_wdata;
         wstrb_d  = s_axil_wstrb;
      end
      if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;

      if (wr_commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = (wsel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
         case (wsel)
            SEL_SRC:     src_d     = apply_strb(src_q, wdata_q, wstrb_q);
            SEL_DST:     dst_d     = apply_strb(dst_q, wdata_q, wstrb_q);
            SEL_SCRATCH: scratch_d = apply_strb(scratch_q, wdata_q, wstrb_q);
            SEL_LEN: begin
               for (int i = 0; i < 3; i++)
                  if (wstrb_q[i]) len_d[i*8 +: 8] = wdata_q[i*8 +: 8];
            end
            default: ;
         endcase
      end

      // Soft reset clears the stickies before START can flag an overrun.
      if (ctrl_b0 && wsel == SEL_CTRL) begin
         irq_en_d = wdata_q[CTRL_IRQ_EN];
         if (wdata_q[CTRL_SOFT_RST]) begin
            soft_rst_d = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            ovr_d      = 1'b0;
         end
         if (wdata_q[CTRL_START]) begin
            if (acc_busy) ovr_d   = 1'b1;
            else          start_d = 1'b1;
         end
      end
      if (ctrl_b0 && wsel == SEL_STATUS) begin
         if (wdata_q[ST_DONE])      done_d = 1'b0;
         if (wdata_q[ST_ERR])       err_d  = 1'b0;
         if (wdata_q[ST_START_OVR]) ovr_d  = 1'b0;
      end
      // Hardware events win over a same-cycle clear.
      if (acc_done) done_d = 1'b1;
      if (acc_err)  err_d  = 1'b1;

      irq_d = irq_en_d & (done_d | err_d);
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = RESP_OKAY;
         rdata_d  = '0;
         case (rsel)
            SEL_CTRL:    rdata_d[CTRL_IRQ_EN] = irq_en_q;
            SEL_STATUS:  rdata_d[3:0] = {ovr_q, err_q, done_q, acc_busy};
            SEL_SRC:     rdata_d = src_q;
            SEL_DST:     rdata_d = dst_q;
            SEL_LEN:     rdata_d = {8'h00, len_q};
            SEL_SCRATCH: rdata_d = scratch_q;
            SEL_VERSION: rdata_d = VERSION;
            default:     rresp_d = RESP_SLVERR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdy_en_q   <= 1'b0;
         aw_held_q  <= 1'b0;
         awaddr_q   <= '0;
         w_held_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         irq_en_q   <= 1'b0;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         scratch_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
         start_q    <= 1'b0;
         soft_rst_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         rdy_en_q   <= rdy_en_d;
         aw_held_q  <= aw_held_d;
         awaddr_q   <= awaddr_d;
         w_held_q   <= w_held_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         irq_en_q   <= irq_en_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         scratch_q  <= scratch_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ovr_q      <= ovr_d;
         start_q    <= start_d;
         soft_rst_q <= soft_rst_d;
         irq_q      <= irq_d;
      end
   end

   assign s_axil_bvalid = bvalid_q;
   assign s_axil_bresp  = bresp_q;
   assign s_axil_rvalid = rvalid_q;
   assign s_axil_rdata  = rdata_q;
   assign s_axil_rresp  = rresp_q;
   assign acc_start     = start_q;
   assign acc_soft_rst  = soft_rst_q;
   assign acc_src_addr  = src_q;
   assign acc_dst_addr  = dst_q;
   assign acc_len       = len_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_axil_accel_regs.sv
// Bench for axil_accel_regs: directed scenarios plus randomized traffic
// checked against a register-level model of the map.
module tb_axil_accel_regs;

   logic        clk = 1'b0;
   logic        resetn;
   logic [5:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        acc_start, acc_soft_rst, acc_busy, acc_done, acc_err, irq;
   logic [31:0] acc_src_addr, acc_dst_addr;
   logic [23:0] acc_len;

   int vec_cnt = 0;
   int err_cnt = 0;
   int start_cnt = 0;
   int soft_cnt = 0;

   // Reference model state
   bit          m_irq_en, m_done, m_err, m_ovr;
   logic [31:0] m_src, m_dst, m_scr;
   logic [23:0] m_len;
   int          exp_start = 0;
   int          exp_soft = 0;

   always #5 clk = ~clk;

   axil_accel_regs #(.ADDR_WIDTH(6), .VERSION(32'h0001_0000)) dut (
      .clk(clk), .resetn(resetn),
      .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
      .acc_start(acc_start), .acc_soft_rst(acc_soft_rst),
      .acc_src_addr(acc_src_addr), .acc_dst_addr(acc_dst_addr), .acc_len(acc_len),
      .acc_busy(acc_busy), .acc_done(acc_done), .acc_err(acc_err), .irq(irq)
   );

   always @(negedge clk) begin
      if (acc_start)    start_cnt++;
      if (acc_soft_rst) soft_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_irq_en = 0; m_done = 0; m_err = 0; m_ovr = 0;
      m_src = 0; m_dst = 0; m_scr = 0; m_len = 0;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
      return r;
   endfunction

   function automatic logic [1:0] model_write(input logic [5:0] a, input logic [31:0] d,
                                              input logic [3:0] s, input bit busy,
                                              input bit done_evt);
      logic [1:0]  r = 2'b00;
      logic [31:0] l;
      case (a)
         6'h00: if (s[0]) begin
            if (d[2]) begin exp_soft++; m_done = 0; m_err = 0; m_ovr = 0; end
            if (d[0]) begin if (busy) m_ovr = 1; else exp_start++; end
            m_irq_en = d[1];
         end
         6'h04: if (s[0]) begin
            if (d[1]) m_done = 0;
            if (d[2]) m_err = 0;
            if (d[3]) m_ovr = 0;
         end
         6'h08: m_src = merge(m_src, d, s);
         6'h0C: m_dst = merge(m_dst, d, s);
         6'h10: begin l = merge({8'h00, m_len}, d, s); m_len = l[23:0]; end
         6'h14: m_scr = merge(m_scr, d, s);
         6'h18: ;
         default: r = 2'b10;
      endcase
      if (done_evt) m_done = 1;
      return r;
   endfunction

   function automatic void model_read(input logic [5:0] a, input bit busy,
                                      output logic [31:0] d, output logic [1:0] r);
      r = 2'b00;
      case (a)
         6'h00: d = {30'd0, m_irq_en, 1'b0};
         6'h04: d = {28'd0, m_ovr, m_err, m_done, busy};
         6'h08: d = m_src;
         6'h0C: d = m_dst;
         6'h10: d = {8'h00, m_len};
         6'h14: d = m_scr;
         6'h18: d = 32'h0001_0000;
         default: begin d = 32'h0; r = 2'b10; end
      endcase
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Drives AW and W with W offset by 'lead' cycles (negative: W first),
   // holds bready low for 'bhold' cycles, optionally pulses acc_done so it
   // coincides with the commit edge.
   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bhold, input bit done_at_commit,
                            output logic [1:0] resp);
      int cyc = 0;
      bit aw_done = 0, w_done = 0, aw_go, w_go;
      while (!(aw_done && w_done) && cyc < 40) begin
         if (!aw_done && cyc >= (lead < 0 ? -lead : 0)) begin awvalid = 1; awaddr = a; end
         if (!w_done && cyc >= (lead > 0 ? lead : 0)) begin wvalid = 1; wdata = d; wstrb = s; end
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         step();
         if (aw_go) begin awvalid = 0; aw_done = 1; end
         if (w_go)  begin wvalid = 0;  w_done = 1;  end
         cyc++;
      end
      awvalid = 0; wvalid = 0;
      vec_cnt++;
      if (!(aw_done && w_done)) begin
         err_cnt++;
         $display("FAIL wr_handshake_timeout addr=%h aw=%0d w=%0d", a, aw_done, w_done);
      end
      vec_cnt++;
      if (bvalid !== 1'b0) begin
         err_cnt++; $display("FAIL wr_bvalid_early got %b exp 0", bvalid);
      end
      acc_done = done_at_commit;
      step();
      acc_done = 0;
      vec_cnt++;
      if (bvalid !== 1'b1) begin
         err_cnt++; $display("FAIL wr_latency bvalid got %b exp 1", bvalid);
      end
      resp = bresp;
      for (int t = 0; t < bhold; t++) begin
         vec_cnt++;
         if ({bvalid, awready, wready} !== 3'b100) begin
            err_cnt++;
            $display("FAIL wr_bhold cyc=%0d {bvalid,awready,wready} got %b exp 100", t,
                     {bvalid, awready, wready});
         end
         step();
      end
      bready = 1;
      step();
      bready = 0;
      vec_cnt++;
      if (bvalid !== 1'b0) begin
         err_cnt++; $display("FAIL wr_bvalid_clear got %b exp 0", bvalid);
      end
   endtask

   task automatic axi_read(input logic [5:0] a, input int rhold,
                           output logic [31:0] d, output logic [1:0] resp);
      int cyc = 0;
      bit go = 0;
      arvalid = 1; araddr = a;
      while (!go && cyc < 20) begin
         go = arready;
         step();
         cyc++;
      end
      arvalid = 0;
      vec_cnt++;
      if (!go || rvalid !== 1'b1) begin
         err_cnt++; $display("FAIL rd_latency addr=%h hs=%0d rvalid got %b exp 1", a, go, rvalid);
      end
      d = rdata; resp = rresp;
      for (int t = 0; t < rhold; t++) begin
         step();
         vec_cnt++;
         if (rvalid !== 1'b1 || rdata !== d || arready !== 1'b0) begin
            err_cnt++;
            $display("FAIL rd_stall cyc=%0d rvalid=%b arready=%b rdata got %h exp %h",
                     t, rvalid, arready, rdata, d);
         end
      end
      rready = 1;
      step();
      rready = 0;
   endtask

   task automatic pulse_done();
      acc_done = 1; step(); acc_done = 0; m_done = 1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [1:0]  r;
      resetn = 0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
      acc_busy = 0; acc_done = 0; acc_err = 0;
      repeat (3) step();
      vec_cnt++;
      if ({awready, wready, arready, bvalid, rvalid, irq, acc_start, acc_soft_rst} !== 8'h00) begin
         err_cnt++;
         $display("FAIL reset_ctrl_outputs got %b exp 00000000",
                  {awready, wready, arready, bvalid, rvalid, irq, acc_start, acc_soft_rst});
      end
      vec_cnt++;
      if ({bresp, rresp} !== 4'b0000 || {acc_src_addr, acc_dst_addr, acc_len} !== 88'd0) begin
         err_cnt++;
         $display("FAIL reset_values resp=%b src=%h dst=%h len=%h", {bresp, rresp},
                  acc_src_addr, acc_dst_addr, acc_len);
      end
      resetn = 1;
      #1;
      vec_cnt++;
      if ({awready, wready, arready} !== 3'b000) begin
         err_cnt++; $display("FAIL reset_ready_early got %b exp 000", {awready, wready, arready});
      end
      step();
      vec_cnt++;
      if ({awready, wready, arready} !== 3'b111) begin
         err_cnt++; $display("FAIL reset_ready_rise got %b exp 111", {awready, wready, arready});
      end
      model_reset();
      axi_read(6'h18, 0, d, r);
      vec_cnt++;
      if (d !== 32'h0001_0000 || r !== 2'b00) begin
         err_cnt++; $display("FAIL version_read got %h/%b exp 00010000/00", d, r);
      end
   endtask

   task automatic test_strb_aw_lead();
      logic [31:0] d;
      logic [1:0]  r;
      axi_write(6'h14, 32'hDEAD_BEEF, 4'b0101, 3, 0, 0, r);
      void'(model_write(6'h14, 32'hDEAD_BEEF, 4'b0101, 0, 0));
      vec_cnt++;
      if (r !== 2'b00) begin err_cnt++; $display("FAIL scratch_bresp got %b exp 00", r); end
      axi_read(6'h14, 0, d, r);
      vec_cnt++;
      if (d !== 32'h00AD_00EF) begin
         err_cnt++; $display("FAIL scratch_strb got %h exp 00ad00ef", d);
      end
   endtask

   task automatic test_start_irq();
      logic [31:0] d;
      logic [1:0]  r;
      int s0 = start_cnt;
      acc_busy = 0;
      axi_write(6'h00, 32'h3, 4'hF, 0, 0, 0, r);
      void'(model_write(6'h00, 32'h3, 4'hF, 0, 0));
      repeat (2) step();
      vec_cnt++;
      if (start_cnt - s0 != 1) begin
         err_cnt++; $display("FAIL start_pulse_cycles got %0d exp 1", start_cnt - s0);
      end
      pulse_done();
      step();
      axi_read(6'h04, 0, d, r);
      vec_cnt++;
      if (d !== 32'h2 || irq !== 1'b1) begin
         err_cnt++; $display("FAIL done_status status=%h irq=%b exp 2/1", d, irq);
      end
      axi_write(6'h04, 32'h2, 4'hF, 0, 0, 0, r);
      void'(model_write(6'h04, 32'h2, 4'hF, 0, 0));
      step();
      vec_cnt++;
      if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_clear got %b exp 0", irq); end
   endtask

   task automatic test_start_ovr();
      logic [31:0] d;
      logic [1:0]  r;
      int s0 = start_cnt;
      acc_busy = 1;
      axi_write(6'h00, 32'h1, 4'hF, -2, 0, 0, r);
      void'(model_write(6'h00, 32'h1, 4'hF, 1, 0));
      repeat (2) step();
      vec_cnt++;
      if (start_cnt != s0) begin
         err_cnt++; $display("FAIL start_while_busy pulses got %0d exp 0", start_cnt - s0);
      end
      axi_read(6'h04, 0, d, r);
      vec_cnt++;
      if (d !== 32'h9) begin err_cnt++; $display("FAIL ovr_status got %h exp 9", d); end
      pulse_done();
      axi_write(6'h04, 32'h2, 4'h1, 1, 0, 1, r);
      void'(model_write(6'h04, 32'h2, 4'h1, 1, 1));
      axi_read(6'h04, 0, d, r);
      vec_cnt++;
      if (d !== 32'hB) begin err_cnt++; $display("FAIL set_beats_w1c got %h exp b", d); end
      acc_busy = 0;
   endtask

   task automatic test_soft_rst();
      logic [31:0] d;
      logic [1:0]  r;
      int s0 = soft_cnt;
      axi_write(6'h08, 32'h1234_5678, 4'hF, 0, 0, 0, r);
      void'(model_write(6'h08, 32'h1234_5678, 4'hF, 0, 0));
      axi_write(6'h00, 32'h6, 4'h1, 0, 0, 0, r);
      void'(model_write(6'h00, 32'h6, 4'h1, 0, 0));
      repeat (2) step();
      vec_cnt++;
      if (soft_cnt - s0 != 1) begin
         err_cnt++; $display("FAIL soft_rst_pulse got %0d exp 1", soft_cnt - s0);
      end
      axi_read(6'h04, 0, d, r);
      vec_cnt++;
      if (d !== 32'h0) begin err_cnt++; $display("FAIL soft_rst_status got %h exp 0", d); end
      vec_cnt++;
      if (acc_src_addr !== 32'h1234_5678) begin
         err_cnt++; $display("FAIL soft_rst_keeps_src got %h exp 12345678", acc_src_addr);
      end
      axi_read(6'h00, 0, d, r);
      vec_cnt++;
      if (d !== 32'h2) begin err_cnt++; $display("FAIL soft_rst_keeps_irqen got %h exp 2", d); end
   endtask

   task automatic test_unmapped();
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(6'h20, 0, d, r);
      vec_cnt++;
      if (d !== 32'h0 || r !== 2'b10) begin
         err_cnt++; $display("FAIL unmapped_read got %h/%b exp 0/10", d, r);
      end
      axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
      vec_cnt++;
      if (r !== 2'b10) begin err_cnt++; $display("FAIL unmapped_write_resp got %b exp 10", r); end
      axi_write(6'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
      vec_cnt++;
      if (r !== 2'b00) begin err_cnt++; $display("FAIL version_write_resp got %b exp 00", r); end
      axi_read(6'h18, 0, d, r);
      vec_cnt++;
      if (d !== 32'h0001_0000) begin err_cnt++; $display("FAIL version_ro got %h exp 00010000", d); end
      axi_read(6'h14, 0, d, r);
      vec_cnt++;
      if (d !== 32'h00AD_00EF) begin err_cnt++; $display("FAIL unmapped_no_side_effect got %h", d); end
   endtask

   task automatic test_back_pressure();
      logic [31:0] d;
      logic [1:0]  r;
      axi_write(6'h0C, 32'hCAFE_F00D, 4'hF, 0, 5, 0, r);
      void'(model_write(6'h0C, 32'hCAFE_F00D, 4'hF, 0, 0));
      axi_read(6'h0C, 3, d, r);
      vec_cnt++;
      if (d !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL dst_readback got %h exp cafef00d", d); end
   endtask

   task automatic test_random();
      logic [31:0] d, ed;
      logic [1:0]  r, er;
      logic [5:0]  a;
      logic [3:0]  s;
      for (int i = 0; i < 60; i++) begin
         a = 6'($urandom_range(0, 15) * 4);
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         if (a == 6'h00 && d[0] && d[2]) d[2] = 1'b0;
         acc_busy = 1'($urandom_range(0, 1));
         axi_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)), 0, r);
         er = model_write(a, d, s, acc_busy, 0);
         vec_cnt++;
         if (r !== er) begin
            err_cnt++; $display("FAIL rand_bresp i=%0d addr=%h got %b exp %b", i, a, r, er);
         end
         if ($urandom_range(0, 3) == 0) pulse_done();
         if ($urandom_range(0, 4) == 0) begin acc_err = 1; step(); acc_err = 0; m_err = 1; end
         a = 6'($urandom_range(0, 15) * 4);
         axi_read(a, int'($urandom_range(0, 2)), d, r);
         model_read(a, acc_busy, ed, er);
         vec_cnt++;
         if (d !== ed || r !== er) begin
            err_cnt++;
            $display("FAIL rand_read i=%0d addr=%h got %h/%b exp %h/%b", i, a, d, r, ed, er);
         end
         vec_cnt++;
         if (irq !== (m_irq_en & (m_done | m_err))) begin
            err_cnt++; $display("FAIL rand_irq i=%0d got %b exp %b", i, irq,
                                m_irq_en & (m_done | m_err));
         end
      end
      acc_busy = 0;
      repeat (2) step();
      vec_cnt++;
      if (start_cnt != exp_start || soft_cnt != exp_soft) begin
         err_cnt++;
         $display("FAIL pulse_totals start got %0d exp %0d soft got %0d exp %0d",
                  start_cnt, exp_start, soft_cnt, exp_soft);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [1:0]  r;
      arvalid = 1; araddr = 6'h14;
      step();
      arvalid = 0;
      resetn = 0;
      #1;
      vec_cnt++;
      if ({rvalid, arready, awready, wready, irq} !== 5'b0) begin
         err_cnt++;
         $display("FAIL reset_mid_drop got %b exp 00000", {rvalid, arready, awready, wready, irq});
      end
      repeat (2) step();
      resetn = 1;
      step();
      model_reset();
      axi_read(6'h14, 0, d, r);
      vec_cnt++;
      if (d !== 32'h0 || r !== 2'b00) begin
         err_cnt++; $display("FAIL reset_mid_scratch got %h/%b exp 0/00", d, r);
      end
   endtask

   initial begin
      test_reset();
      test_strb_aw_lead();
      test_start_irq();
      test_start_ovr();
      test_soft_rst();
      test_unmapped();
      test_back_pressure();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/axil_accel_regs.md
# axil_accel_regs

AXI4-Lite responder holding the control/status register file for the PL accelerator. The PS7 general-purpose master port drives it. It turns register writes into accelerator controls: start pulse, soft-reset pulse, and source/destination/length configuration. It folds accelerator status back into readable sticky bits and a level interrupt to the PS.

## Interface
Parameters:
- ADDR_WIDTH, 6, byte-address width; decode uses bits [ADDR_WIDTH-1:2].
- VERSION, 32'h0001_0000, value returned by the VERSION register.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous, active-low reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awvalid / s_axil_awready  in/out  1  write-address handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte strobes.
- s_axil_wvalid / s_axil_wready  in/out  1  write-data handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid / s_axil_bready  out/in  1  write-response handshake.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arvalid / s_axil_arready  in/out  1  read-address handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid / s_axil_rready  out/in  1  read-data handshake.
- acc_start  out  1  one-cycle start pulse.
- acc_soft_rst  out  1  one-cycle accelerator reset pulse.
- acc_src_addr, acc_dst_addr  out  32  configured addresses.
- acc_len  out  24  configured length in bytes.
- acc_busy  in  1  accelerator running (level).
- acc_done, acc_err  in  1  completion / error pulses.
- irq  out  1  level interrupt.

## Operation
Register map (word offsets):
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (RW); bit2 SOFT_RST (write-1 pulse, reads 0).
- 0x04 STATUS: bit0 BUSY (live acc_busy); bit1 DONE, bit2 ERR, bit3 START_OVR. Bits 1–3 are sticky, write-1-to-clear.
- 0x08 SRC_ADDR (RW). 0x0C DST_ADDR (RW).
- 0x10 LEN (RW, bits 23:0; bits 31:24 read 0).
- 0x14 SCRATCH (RW). 0x18 VERSION (RO).
- 0x1C–end: unmapped. Reads return 0 with SLVERR; writes are ignored with SLVERR.

Behaviour:
- WSTRB is honoured per byte on all RW registers. A CTRL pulse bit acts only if byte 0 is strobed.
- START while acc_busy=1: no acc_start pulse; START_OVR is set instead.
- acc_done sets DONE. acc_err sets ERR. A set in the same cycle as a W1C of the same bit wins.
- SOFT_RST pulses acc_soft_rst and clears DONE/ERR/START_OVR. SRC/DST/LEN/SCRATCH/IRQ_EN are kept.
- irq is registered: IRQ_EN & (DONE | ERR).
- Writes to VERSION and STATUS bit0 are ignored with OKAY.
- AWPROT/ARPROT are not ported.

## Timing
- Reset values: all registers 0; all *ready, bvalid, rvalid, irq, acc_start and acc_soft_rst low; bresp/rresp = OKAY.
- After resetn deasserts: awready/wready/arready go high on the first clk edge.
- Write channel:
  - AW and W are captured independently. awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
  - Commit happens on the edge after both are held; the same edge raises bvalid. Latency is 1 cycle from the later handshake.
  - bvalid holds until bready. Both readies stay low meanwhile.
  - acc_start/acc_soft_rst are high for exactly the one cycle after commit.
- Read channel:
  - arready = !rvalid. rdata/rresp are registered at the AR handshake edge; rvalid rises on the same edge.
  - rvalid and rdata stay stable until rready. Back-to-back reads therefore give at most one read per 2 cycles.
- Reads and writes are fully independent. A read of STATUS in the cycle a write commits returns the pre-commit value.
- resetn asserted mid-transaction: all channels drop immediately and the outstanding response is discarded.

## Structure
- Package axil_accel_pkg holds:
  - register offset localparams;
  - CTRL/STATUS bit indices;
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
- Single module; no sub-module. The write capture/response logic and the read mux live inline.

## Test plan
- Reset, then read 0x18 -> rdata = 32'h0001_0000, rresp = OKAY.
- AW issued 3 cycles before W, writing 32'hDEAD_BEEF to 0x14 with wstrb = 4'b0101 -> bvalid 1 cycle after W handshake; readback = 32'h00AD_00EF.
- Write 0x00 = 32'h3 with acc_busy = 0 -> acc_start high for exactly 1 cycle. Then pulse acc_done -> STATUS reads 0x2 and irq = 1. Write 0x04 = 0x2 -> irq falls.
- START with acc_busy = 1 -> no acc_start; STATUS = 0x9. W1C of DONE in the same cycle as an acc_done pulse -> DONE stays 1.
- Read 0x20 -> rdata = 0, rresp = SLVERR. Hold bready low 5 cycles -> awready/wready stay low and bvalid stays high throughout.
